// File: rtl/l0_skew_fifo.sv
// L0 input buffer: row lane FIFOs with one shared push, popped in broadcast or skewed-wavefront order.
// Optional L0_OCC_EN: drives occ with lane-0 entry count; otherwise occ is tied to 0.

module l0_skew_lane #(
  parameter int bw    = 4,
  parameter int depth = 64,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [aw-1:0] wptr_i,
  input  logic [bw-1:0] din_i,
  input  logic          rd_en_i,
  output logic [bw-1:0] dout_o,
  output logic          vld_o,
  output logic [aw:0]   cnt_o
);
  logic [bw-1:0] mem_q [depth];
  logic [aw-1:0] rptr_q;
  logic [aw:0]   cnt_q;
  logic [bw-1:0] dout_q;
  logic          vld_q;
  logic          pop;

  // An enabled pop on an empty lane is a no-op; out keeps its last value.
  assign pop = rd_en_i && (cnt_q != '0);

  always_ff @(posedge clk)
    if (push_i) mem_q[wptr_i] <= din_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= pop;
      if (pop) begin
        dout_q <= mem_q[rptr_q];
        rptr_q <= rptr_q + aw'(1);
      end
      case ({push_i, pop})
        2'b10:   cnt_q <= cnt_q + (aw+1)'(1);
        2'b01:   cnt_q <= cnt_q - (aw+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o = dout_q;
  assign vld_o  = vld_q;
  assign cnt_o  = cnt_q;
endmodule

module l0_skew_fifo #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64,
  parameter int aw    = $clog2(depth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [row*bw-1:0] in,
  input  logic              wr,
  input  logic              rd,
  input  logic              mode,
  output logic [row*bw-1:0] out,
  output logic [row-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
  output logic              o_busy,
  output logic [aw:0]       occ
);
  logic [aw-1:0]        wptr_q;
  logic [row-1:0]       rd_en_q, rd_en_d;
  logic                 mode_q, mode_d, mode_eff;
  logic                 push;
  logic [row-1:0][aw:0] cnt;

  assign push = wr && !o_full && !reset;

  for (genvar i = 0; i < row; i++) begin : g_lane
    l0_skew_lane #(.bw(bw), .depth(depth), .aw(aw)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .push_i (push),
      .wptr_i (wptr_q),
      .din_i  (in[bw*i +: bw]),
      .rd_en_i(rd_en_q[i]),
      .dout_o (out[bw*i +: bw]),
      .vld_o  (o_valid[i]),
      .cnt_o  (cnt[i])
    );
  end

  always_comb begin
    o_full  = 1'b0;
    o_empty = 1'b1;
    for (int i = 0; i < row; i++) begin
      o_full  = o_full  | (cnt[i] == (aw+1)'(depth));
      o_empty = o_empty & (cnt[i] == '0);
    end
  end

  assign o_ready = ~o_full;
  assign o_busy  = |rd_en_q;

  // Mode can only change between waves so a wave never mixes shapes.
  always_comb begin
    mode_eff = o_busy ? mode_q : mode;
    mode_d   = o_busy ? mode_q : mode;
    if (mode_eff) rd_en_d = (rd_en_q << 1) | row'(rd);
    else          rd_en_d = {row{rd}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rd_en_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + aw'(1);
      rd_en_q <= rd_en_d;
      mode_q  <= mode_d;
    end
  end

`ifdef L0_OCC_EN
  assign occ = cnt[0];
`else
  assign occ = '0;
`endif
endmodule

// File: tb/tb_l0_skew_fifo.sv
// Directed self-checking bench for l0_skew_fifo (row=8, bw=4, depth=64).
module tb_l0_skew_fifo;
  logic        clk = 1'b0;
  logic        reset, wr, rd, mode;
  logic [31:0] in, out;
  logic [7:0]  o_valid;
  logic        o_full, o_ready, o_empty, o_busy;
  logic [6:0]  occ;

  int n_chk = 0;
  int n_err = 0;

  l0_skew_fifo #(.row(8), .bw(4), .depth(64)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .mode(mode),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .o_empty(o_empty), .o_busy(o_busy), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkdata(input int j);
    return 32'(j + 1) * 32'h9E3779B9;
  endfunction

  function automatic logic [6:0] occ_exp(input int n);
`ifdef L0_OCC_EN
    return 7'(n);
`else
    return (n == n) ? 7'd0 : 7'd1;
`endif
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"},   out, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_empty"}, o_empty, 1);
    chk({tag, "_full"},  o_full, 0);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_occ"},   occ, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, p0, eo;
    logic [7:0]  ev;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; mode = 1'b0; in = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    chk_reset_state("rst");

    // Broadcast: three pushes, one pop
    wr = 1'b1;
    in = 32'h76543210; tick;
    in = 32'hFEDCBA98; tick;
    in = 32'h11111111; tick;
    wr = 1'b0;
    chk("bc_empty", o_empty, 0);
    chk("bc_occ3", occ, occ_exp(3));
    rd = 1'b1; tick;
    chk("bc_busy", o_busy, 1);
    chk("bc_valid_t1", o_valid, 8'h00);
    rd = 1'b0; tick;
    chk("bc_out", out, 32'h76543210);
    chk("bc_valid", o_valid, 8'hFF);
    chk("bc_occ2", occ, occ_exp(2));
    tick;
    chk("bc_valid_off", o_valid, 8'h00);
    chk("bc_hold", out, 32'h76543210);
    chk("bc_idle", o_busy, 0);
    rd = 1'b1; tick; tick;
    chk("bc_out2", out, 32'hFEDCBA98);
    rd = 1'b0; tick;
    chk("bc_out3", out, 32'h11111111);
    chk("bc_drained", o_empty, 1);
    tick;

    // Skew: two pushes, rd held two cycles, mode flipped mid-wave
    mode = 1'b1; tick;
    a = 32'h89ABCDEF; b = 32'h13579BDF;
    wr = 1'b1;
    in = a; tick;
    in = b; tick;
    wr = 1'b0;
    rd = 1'b1; tick;
    chk("sk_busy_k1", o_busy, 1);
    chk("sk_valid_k1", o_valid, 0);
    for (int k = 2; k <= 11; k++) begin
      tick;
      for (int i = 0; i < 8; i++) begin
        ev[i] = (k == 2 + i) || (k == 3 + i);
        if (k < 2 + i)       eo[4*i +: 4] = 4'h1;
        else if (k == 2 + i) eo[4*i +: 4] = a[4*i +: 4];
        else                 eo[4*i +: 4] = b[4*i +: 4];
      end
      chk($sformatf("sk_valid_k%0d", k), o_valid, ev);
      chk($sformatf("sk_out_k%0d", k), out, eo);
      chk($sformatf("sk_busy_k%0d", k), o_busy, (k <= 9) ? 1 : 0);
      if (k == 2) begin rd = 1'b0; mode = 1'b0; end
    end
    chk("sk_empty", o_empty, 1);

    // Fill to depth with pointer wrap, then broadcast drain
    wr = 1'b1;
    for (int j = 0; j < 64; j++) begin
      in = mkdata(j); tick;
      if (j == 62) chk("fill_notfull63", o_full, 0);
    end
    chk("fill_full", o_full, 1);
    chk("fill_ready", o_ready, 0);
    chk("fill_occ", occ, occ_exp(64));
    in = 32'hDEADBEEF; tick;
    wr = 1'b0;
    chk("drop_full", o_full, 1);
    chk("drop_occ", occ, occ_exp(64));
    rd = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick;
      if (k >= 1) begin
        chk($sformatf("drain_out%0d", k - 1), out, mkdata(k - 1));
        chk($sformatf("drain_vld%0d", k - 1), o_valid, 8'hFF);
      end
      if (k == 1) chk("drain_notfull", o_full, 0);
      if (k == 10) mode = 1'b1;
    end
    rd = 1'b0; tick;
    chk("drain_out63", out, mkdata(63));
    chk("drain_empty", o_empty, 1);
    tick;
    chk("drain_vld_off", o_valid, 0);
    chk("drain_idle", o_busy, 0);

    // Pop on empty; mode=1 took effect after the wave so this wave is skewed
    rd = 1'b1; tick;
    rd = 1'b0; tick; tick; tick;
    chk("ep_skew_busy", o_busy, 1);
    chk("ep_valid", o_valid, 0);
    chk("ep_hold", out, mkdata(63));
    repeat (5) tick;
    chk("ep_busy_done", o_busy, 0);
    chk("ep_hold2", out, mkdata(63));
    mode = 1'b0; tick;

    // Same-cycle push and pop at count 5
    wr = 1'b1;
    for (int j = 0; j < 5; j++) begin in = mkdata(200 + j); tick; end
    wr = 1'b0;
    chk("pp_occ5", occ, occ_exp(5));
    rd = 1'b1; tick;
    rd = 1'b0; wr = 1'b1; in = mkdata(205); tick;
    wr = 1'b0;
    p0 = mkdata(200);
    chk("pp_out", out, p0);
    chk("pp_occ", occ, occ_exp(5));
    rd = 1'b1; tick;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) rd = 1'b0;
      tick;
      chk($sformatf("pp_pop%0d", k), out, mkdata(200 + k));
      chk($sformatf("pp_vld%0d", k), o_valid, 8'hFF);
    end
    chk("pp_empty", o_empty, 1);
    tick;

    // Reset mid skew wave
    mode = 1'b1; tick;
    wr = 1'b1;
    for (int j = 0; j < 3; j++) begin in = mkdata(300 + j); tick; end
    wr = 1'b0;
    rd = 1'b1; tick; tick;
    chk("mr_lane0", o_valid, 8'h01);
    reset = 1'b1; tick;
    chk_reset_state("mr");
    reset = 1'b0; rd = 1'b0; tick; tick;
    chk("mr_after_valid", o_valid, 0);
    chk("mr_after_busy", o_busy, 0);
    chk("mr_after_empty", o_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
